// File: rtl/alu_pkg.sv
// Shared flag types and indices for the ALU writeback path.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package alu_pkg;

    localparam int FLAG_W  = 5;

    // Flag vector bit order is {sf,pf,of,zf,cf} = [4:0]
    typedef logic [FLAG_W-1:0] flag_vec_t;

    localparam int FLAG_CF = 0;
    localparam int FLAG_ZF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_PF = 3;
    localparam int FLAG_SF = 4;

    // Masked merge: bits selected by mask take the new value, others keep the old one
    function automatic flag_vec_t merge_flags(input flag_vec_t old_f,
                                              input flag_vec_t new_f,
                                              input flag_vec_t mask);
        return (old_f & ~mask) | (new_f & mask);
    endfunction

endpackage

// File: rtl/alu_wb_queue.sv
// In-order result queue of DEPTH entries; head is always entry 0.
// Latency: a push is visible at the head one cycle after acceptance.
// Backpressure: rdy_o is registered, high when next-cycle occupancy is below DEPTH.
module alu_wb_queue #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 21
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             vld_o,
    output logic             rdy_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_occ;
    logic             r_rdy;
    logic [CW-1:0]    w_occ_nxt;
    logic [CW-1:0]    w_wr_idx;

    // Next occupancy and write slot; a pop shifts everything down one slot first
    always_comb begin
        w_occ_nxt = r_occ;
        if (flush_i) begin
            w_occ_nxt = '0;
        end else if (push_i && !pop_i) begin
            w_occ_nxt = r_occ + CW'(1);
        end else if (!push_i && pop_i) begin
            w_occ_nxt = r_occ - CW'(1);
        end
        w_wr_idx = pop_i ? (r_occ - CW'(1)) : r_occ;
    end

    // Occupancy and registered ready; ready is derived from next occupancy so no comb path
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_occ <= '0;
            r_rdy <= 1'b1;
        end else begin
            r_occ <= w_occ_nxt;
            r_rdy <= (w_occ_nxt < CW'(DEPTH));
        end
    end

    // Storage: shift on pop, then write the pushed entry behind the surviving ones
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!flush_i) begin
            if (pop_i) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push_i && (w_wr_idx == CW'(i))) begin
                    r_mem[i] <= dat_i;
                end
            end
        end
    end

    assign dat_o = r_mem[0];
    assign vld_o = (r_occ != '0);
    assign rdy_o = r_rdy;

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback: masked architectural flag update plus in-order result queue (ALU_WB_SKID_EN -> depth 2).
// Latency: 1 cycle from accept to out_valid_o; carry feedback updates on the accept edge.
// Backpressure: in_ready_o is registered; depth 1 gives one transfer per two cycles, depth 2 one per cycle.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WORD_WIDTH-1:0] r_i,
    input  logic                  cf_i,
    input  logic                  zf_i,
    input  logic                  of_i,
    input  logic                  pf_i,
    input  logic                  sf_i,
    input  logic [FLAG_W-1:0]     flag_mask_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WORD_WIDTH-1:0] r_o,
    output logic [FLAG_W-1:0]     flags_o,
    output logic                  cf_fb_o
);

`ifdef ALU_WB_SKID_EN
    localparam int QDEPTH = 2;
`else
    localparam int QDEPTH = 1;
`endif

    localparam int ENTRY_W = WORD_WIDTH + FLAG_W;

    flag_vec_t          r_arch_flags;
    flag_vec_t          w_in_flags;
    flag_vec_t          w_flags_nxt;
    logic               w_push;
    logic               w_pop;
    logic               w_q_vld;
    logic               w_q_rdy;
    logic [ENTRY_W-1:0] w_head;

    // Gather incoming flags and compute post-update architectural flags
    always_comb begin
        w_in_flags          = '0;
        w_in_flags[FLAG_CF] = cf_i;
        w_in_flags[FLAG_ZF] = zf_i;
        w_in_flags[FLAG_OF] = of_i;
        w_in_flags[FLAG_PF] = pf_i;
        w_in_flags[FLAG_SF] = sf_i;
        w_flags_nxt         = merge_flags(r_arch_flags, w_in_flags, flag_mask_i);
    end

    // A flush swallows any same-cycle input, so it neither enqueues nor touches flags
    assign w_push = in_valid_i & w_q_rdy & ~flush_i;
    assign w_pop  = w_q_vld & out_ready_i;

    // Architectural flags change only on an accepted input
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_arch_flags <= '0;
        end else if (w_push) begin
            r_arch_flags <= w_flags_nxt;
        end
    end

    alu_wb_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (flush_i),
        .dat_i   ({w_flags_nxt, r_i}),
        .dat_o   (w_head),
        .vld_o   (w_q_vld),
        .rdy_o   (w_q_rdy)
    );

    assign in_ready_o  = w_q_rdy;
    assign out_valid_o = w_q_vld;
    assign r_o         = w_head[WORD_WIDTH-1:0];
    assign flags_o     = w_head[ENTRY_W-1:WORD_WIDTH];
    assign cf_fb_o     = r_arch_flags[FLAG_CF];

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage (WORD_WIDTH=16).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised via out_ready_i hold/pop and flush sequences.
module tb_alu_writeback_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] r_i;
    logic        cf_i, zf_i, of_i, pf_i, sf_i;
    logic [4:0]  flag_mask_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] r_o;
    logic [4:0]  flags_o;
    logic        cf_fb_o;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef ALU_WB_SKID_EN
    localparam logic RDY_AT_OCC1 = 1'b1;
    localparam int   EXP_ACC     = 6;
    localparam int   EXP_POPS    = 5;
`else
    localparam logic RDY_AT_OCC1 = 1'b0;
    localparam int   EXP_ACC     = 3;
    localparam int   EXP_POPS    = 3;
`endif

    alu_writeback_stage #(.WORD_WIDTH(16)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .r_i         (r_i),
        .cf_i        (cf_i),
        .zf_i        (zf_i),
        .of_i        (of_i),
        .pf_i        (pf_i),
        .sf_i        (sf_i),
        .flag_mask_i (flag_mask_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .r_o         (r_o),
        .flags_o     (flags_o),
        .cf_fb_o     (cf_fb_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] r, input logic [4:0] f, input logic [4:0] m);
        r_i         = r;
        {sf_i, pf_i, of_i, zf_i, cf_i} = f;
        flag_mask_i = m;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int pops;
        logic [15:0] exp_pop;
        logic will_acc;

        rst_ni = 1'b0; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        drive(16'h0, 5'b0, 5'b0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_r_o", r_o, 0);
        chk("rst_flags_o", flags_o, 0);
        chk("rst_cf_fb", cf_fb_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        rst_ni = 1'b1;
        step();

        // Single push, all flags updated
        drive(16'h8001, 5'b11001, 5'b11111); in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        chk("push1_valid", out_valid_o, 1);
        chk("push1_r", r_o, 16'h8001);
        chk("push1_flags", flags_o, 5'b11001);
        chk("push1_cf_fb", cf_fb_o, 1);
        chk("push1_in_ready", in_ready_o, RDY_AT_OCC1);
        step();
        chk("hold_r", r_o, 16'h8001);
        chk("hold_valid", out_valid_o, 1);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk("pop1_valid", out_valid_o, 0);
        chk("pop1_in_ready", in_ready_o, 1);

        // Bring architectural flags to 00001
        drive(16'h1234, 5'b00001, 5'b11111); in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        chk("arch1_flags", flags_o, 5'b00001);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk("arch1_pop_valid", out_valid_o, 0);

        // Partial mask: only sf updates
        drive(16'h5678, 5'b10110, 5'b10000); in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        chk("mask_flags", flags_o, 5'b10001);
        chk("mask_cf_fb", cf_fb_o, 1);
        chk("mask_r", r_o, 16'h5678);

`ifdef ALU_WB_SKID_EN
        // Occupancy 1: push and pop in the same cycle
        drive(16'h00AA, 5'b00000, 5'b00000); in_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        chk("pp_valid", out_valid_o, 1);
        chk("pp_r", r_o, 16'h00AA);
        chk("pp_in_ready", in_ready_o, 1);
        drive(16'h00BB, 5'b00000, 5'b00000); in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        chk("full_in_ready", in_ready_o, 0);
`else
        // Full single-entry queue refuses input even while popping
        drive(16'h00AA, 5'b00000, 5'b00000); in_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk("refuse_valid", out_valid_o, 0);
        chk("refuse_in_ready", in_ready_o, 1);
        step();
        in_valid_i = 1'b0;
        chk("late_valid", out_valid_o, 1);
        chk("late_r", r_o, 16'h00AA);
        chk("late_in_ready", in_ready_o, 0);
`endif
        chk("mask0_flags", flags_o, 5'b10001);

        // Flush with a simultaneous push that would clear cf
        drive(16'h00CC, 5'b00000, 5'b00001); in_valid_i = 1'b1; flush_i = 1'b1;
        step();
        in_valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_valid", out_valid_o, 0);
        chk("flush_cf_fb", cf_fb_o, 1);
        chk("flush_in_ready", in_ready_o, 1);

        // Mask 0 push exposes whether the flushed input touched flags
        drive(16'h00DD, 5'b00000, 5'b00000); in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        chk("postflush_flags", flags_o, 5'b10001);
        chk("postflush_r", r_o, 16'h00DD);
`ifdef ALU_WB_SKID_EN
        drive(16'h00EE, 5'b00000, 5'b00000); in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
`endif

        // Asynchronous reset with the queue full
        #3;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", out_valid_o, 0);
        chk("arst_flags", flags_o, 0);
        chk("arst_cf_fb", cf_fb_o, 0);
        chk("arst_r", r_o, 0);
        step();
        chk("arst_in_ready", in_ready_o, 1);
        rst_ni = 1'b1;

        // Back-to-back valid input with continuous out_ready
        acc = 0; pops = 0; exp_pop = 16'h0100;
        drive(16'h0100, 5'b00000, 5'b00000); in_valid_i = 1'b1; out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            will_acc = in_ready_o;
            if (out_valid_o) begin
                chk("b2b_order", r_o, exp_pop);
                exp_pop = exp_pop + 16'h1;
                pops++;
            end
            step();
            if (will_acc) begin
                acc++;
                r_i = r_i + 16'h1;
            end
        end
        in_valid_i = 1'b0;
        chk("b2b_accepts", acc, EXP_ACC);
        chk("b2b_pops", pops, EXP_POPS);

`ifdef ALU_WB_SKID_EN
        // Fill to two, hold a third, then drain in order
        repeat (3) step();
        out_ready_i = 1'b0;
        chk("drain_valid", out_valid_o, 0);
        drive(16'h0001, 5'b00000, 5'b00000); in_valid_i = 1'b1;
        step();
        r_i = 16'h0002;
        step();
        r_i = 16'h0003;
        chk("skid_full_rdy", in_ready_o, 0);
        step();
        chk("skid_held_r", r_o, 16'h0001);
        out_ready_i = 1'b1;
        exp_pop = 16'h0001;
        for (int k = 0; k < 8; k++) begin
            will_acc = in_valid_i & in_ready_o;
            if (out_valid_o) begin
                chk("skid_order", r_o, exp_pop);
                exp_pop = exp_pop + 16'h1;
            end
            step();
            if (will_acc) in_valid_i = 1'b0;
        end
        chk("skid_count", exp_pop, 16'h0004);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
ALU_WRITEBACK_STAGE -- requirements
Module: alu_writeback_stage

Interface
REQ-001 Parameter WORD_WIDTH, default 16, datapath width in bits.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 in_valid_i  input  1  ALU result/flags valid this cycle.
REQ-005 in_ready_o  output  1  stage can accept; transfer when in_valid_i & in_ready_o.
REQ-006 r_i  input  WORD_WIDTH  ALU result (from right_shift_block r_o or sibling blocks).
REQ-007 cf_i, zf_i, of_i, pf_i, sf_i  input  1 each  ALU flags for this result.
REQ-008 flag_mask_i  input  5  per-flag update enable, bit order {sf,pf,of,zf,cf} = [4:0].
REQ-009 flush_i  input  1  synchronous discard of all queued results.
REQ-010 out_valid_o  output  1  head entry valid.
REQ-011 out_ready_i  input  1  consumer accepts; pop when out_valid_o & out_ready_i.
REQ-012 r_o  output  WORD_WIDTH  head entry result.
REQ-013 flags_o  output  5  head entry flag snapshot, same bit order as flag_mask_i.
REQ-014 cf_fb_o  output  1  architectural carry flag, fed back to ALU cf_i.

Function
REQ-015 Architectural flag register (5 bits) SHALL update on accept only: bit k takes new flag when flag_mask_i[k]=1, else holds.
REQ-016 Each accepted entry SHALL store r_i and the post-update architectural flag value.
REQ-017 Latency SHALL be 1 cycle: accept at edge N -> out_valid_o=1 with that entry after edge N.
REQ-018 Entries SHALL leave in acceptance order; r_o/flags_o SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-019 cf_fb_o SHALL equal architectural flag bit 0, registered (updated same edge as REQ-015).
REQ-020 in_ready_o SHALL be a register output, no combinational path from out_ready_i or in_valid_i.
REQ-021 Push and pop in same cycle SHALL leave occupancy unchanged and preserve order.
REQ-022 flush_i=1 SHALL empty the queue at next edge, discard any same-cycle push (no flag update), leave architectural flags unchanged.
REQ-023 Pop while empty SHALL be impossible (out_valid_o=0); out_ready_i ignored when empty.

Reset
REQ-024 rst_ni=0 SHALL immediately clear queue, out_valid_o=0, r_o=0, flags_o=0, architectural flags=0, cf_fb_o=0, in_ready_o=1 after release.
REQ-025 Reset asserted mid-transfer SHALL discard in-flight data; first edge after release SHALL be able to accept.

Configuration
REQ-026 Macro ALU_WB_SKID_EN defined: queue depth 2; in_ready_o=0 only when occupancy 2 and no pop in current cycle's registered view (i.e. in_ready_o = occupancy_next<2); sustains one transfer per cycle under continuous out_ready_i=1.
REQ-027 Macro undefined: queue depth 1; in_ready_o = ~out_valid_o (registered); maximum throughput one transfer per two cycles; all other requirements unchanged.

Structure
REQ-028 Package alu_pkg SHALL hold flag_vec_t (5-bit packed) and flag index constants FLAG_CF=0, FLAG_ZF=1, FLAG_OF=2, FLAG_PF=3, FLAG_SF=4.
REQ-029 Storage and occupancy control SHALL be sub-module alu_wb_queue (parameterised depth/width); flag register logic stays in the top module.

Verification (WORD_WIDTH=16)
REQ-030 Reset then single push r_i=16'h8001, flags {sf,pf,of,zf,cf}=5'b11001, mask 5'b11111 -> next cycle out_valid_o=1, r_o=16'h8001, flags_o=5'b11001, cf_fb_o=1.
REQ-031 Arch flags 5'b00001, push flags 5'b10110 with mask 5'b10000 -> flags_o=5'b10001, cf_fb_o stays 1.
REQ-032 ALU_WB_SKID_EN, out_ready_i=0, push 16'h0001, 16'h0002 -> in_ready_o=0; third push held; raise out_ready_i -> pops 1,2,3 in order, no loss or duplicate.
REQ-033 Occupancy 1, same-cycle push 16'h00AA and pop -> occupancy stays 1, r_o=16'h00AA next cycle.
REQ-034 Occupancy 2 plus flush_i=1 with in_valid_i=1, cf_i=0, mask 5'b00001 -> out_valid_o=0 next cycle, cf_fb_o unchanged.
REQ-035 rst_ni low mid-stream with queue full -> out_valid_o=0, flags_o=0, cf_fb_o=0 immediately; macro-undefined build: back-to-back valid input accepted every second cycle.
